// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: decodes alu_op/funct into a registered control word
// behind a valid/ready handshake, stretching mult/div by MC_CYCLES cycles.
module alu_ctrl_seq #(
  parameter int unsigned CTRL_W    = 5,
  parameter int unsigned MC_CYCLES = 8,
  parameter int unsigned ERR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_op,
  input  logic [5:0]        funct,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl,
  output logic              illegal,
  output logic              busy,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int unsigned CNT_W = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    OUT
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [4:0]         dec_code;
  logic               dec_mc;
  logic               dec_ill;
  logic [CTRL_W-1:0]  dec_ctrl;
  logic               ld;

  always_comb begin
    dec_code = '0;
    dec_mc   = 1'b0;
    dec_ill  = 1'b0;
    case (alu_op)
      3'b000: begin
        case (funct)
          6'h20:   dec_code = 5'b00001;
          6'h22:   dec_code = 5'b00010;
          6'h24:   dec_code = 5'b00011;
          6'h25:   dec_code = 5'b00100;
          6'h26:   dec_code = 5'b00101;
          6'h2A:   dec_code = 5'b00110;
          6'h00:   dec_code = 5'b00111;
          6'h02:   dec_code = 5'b01000;
          6'h03:   dec_code = 5'b01001;
          6'h18: begin
            dec_code = 5'b10000;
            dec_mc   = 1'b1;
          end
          6'h1A: begin
            dec_code = 5'b10001;
            dec_mc   = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      3'b001:  dec_code = 5'b00001;
      3'b010:  dec_code = 5'b00010;
      3'b011:  dec_code = 5'b00011;
      3'b100:  dec_code = 5'b00100;
      3'b101:  dec_code = 5'b00101;
      3'b110:  dec_code = 5'b00110;
      default: dec_code = 5'b00111;
    endcase
  end

  always_comb begin
    dec_ctrl      = '0;
    dec_ctrl[4:0] = dec_code;
  end

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) ld = 1'b1;
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) ld = 1'b1;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (ld) state_nxt = dec_mc ? WAIT : OUT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ctrl    <= '0;
      illegal <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (ld) begin
        ctrl    <= dec_ctrl;
        illegal <= dec_ill;
        if (dec_ill && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
      end
      // Counter only matters in WAIT; it is reloaded on every multi-cycle accept.
      if (ld && dec_mc)                    cnt <= CNT_W'(MC_CYCLES - 1);
      else if (state == WAIT && cnt != '0) cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have parameter CTRL_W, default 5, control word width (>=5); decoded codes zero-extended to CTRL_W.
REQ-002 SHALL have parameter MC_CYCLES, default 8, extra cycles a multi-cycle op (mult/div) holds before presentation (>=1).
REQ-003 SHALL have parameter ERR_W, default 8, width of illegal-instruction counter.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid&in_ready at clk edge.
REQ-008 SHALL have port alu_op  input  3  main-decoder ALU op.
REQ-009 SHALL have port funct  input  6  R-type function field.
REQ-010 SHALL have port out_valid  output  1  ctrl/illegal valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts when out_valid&out_ready at clk edge.
REQ-012 SHALL have port ctrl  output  CTRL_W  registered ALU control word.
REQ-013 SHALL have port illegal  output  1  registered: current request undecodable.
REQ-014 SHALL have port busy  output  1  multi-cycle op in progress.
REQ-015 SHALL have port err_cnt  output  ERR_W  count of accepted illegal requests.

Function
REQ-016 alu_op decode SHALL be: 000 R-type (use funct); 001 ADD 00001; 010 SUB 00010; 011 AND 00011; 100 OR 00100; 101 XOR 00101; 110 SLT 00110; 111 SLL 00111; funct ignored unless alu_op=000.
REQ-017 R-type funct decode SHALL be: 0x20 00001, 0x22 00010, 0x24 00011, 0x25 00100, 0x26 00101, 0x2A 00110, 0x00 00111, 0x02 01000, 0x03 01001, 0x18 10000 (mult, multi-cycle), 0x1A 10001 (div, multi-cycle).
REQ-018 Any other funct with alu_op=000 SHALL produce ctrl=0, illegal=1; illegal is single-cycle class.
REQ-019 FSM SHALL have states IDLE, WAIT, OUT; reset state IDLE.
REQ-020 IDLE: in_ready=1, out_valid=0, busy=0; on accept latch ctrl/illegal, go WAIT if multi-cycle else OUT.
REQ-021 WAIT: in_ready=0, out_valid=0, busy=1; counter loaded MC_CYCLES-1 on entry, decrements each cycle; at 0 go OUT next edge.
REQ-022 OUT: out_valid=1, busy=0, in_ready=out_ready; ctrl/illegal held stable until handshake.
REQ-023 OUT with out_ready&in_valid SHALL load new request same edge and go OUT or WAIT per REQ-020 (throughput one per cycle for single-cycle ops).
REQ-024 OUT with out_ready&!in_valid SHALL go IDLE; OUT with !out_ready SHALL stay, ignoring inputs.
REQ-025 Latency: single-cycle op accepted at edge k SHALL show out_valid after edge k; multi-cycle op after edge k+MC_CYCLES.
REQ-026 err_cnt SHALL increment on each accepted illegal request, saturating at all-ones.
REQ-027 ctrl/illegal SHALL retain last value in IDLE (not cleared after handshake).

Reset
REQ-028 rst_n low SHALL immediately force IDLE, counter 0, ctrl 0, illegal 0, err_cnt 0, out_valid 0, busy 0, in_ready 1, regardless of clk.
REQ-029 Reset asserted in WAIT or OUT SHALL discard the pending request; no out_valid after release until a new accept.

Verification
REQ-030 alu_op=001, funct=010101, out_ready=1 -> next cycle out_valid=1, ctrl=00001, illegal=0.
REQ-031 alu_op=000, funct=010101 -> ctrl=00000, illegal=1, err_cnt 0->1; 300 illegal requests -> err_cnt=255 (ERR_W=8).
REQ-032 alu_op=000, funct=0x18, MC_CYCLES=8 -> busy=1 and in_ready=0 for 8 cycles, then out_valid=1, ctrl=10000.
REQ-033 Back-to-back 0x20,0x22,0x24 with out_ready=1 -> ctrl 00001,00010,00011 on consecutive cycles, no bubbles.
REQ-034 out_ready=0 for 5 cycles in OUT with changing inputs -> ctrl/out_valid stable, in_ready=0; raise out_ready -> single handshake.
REQ-035 rst_n pulsed low mid-WAIT (div) -> outputs per REQ-028 asynchronously; no stale out_valid after release.
